// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-transfer master.
// Commands arrive on a valid/ready stream (cmd_*), are buffered in a small
// FIFO and executed one Wishbone cycle at a time (wb_m2s_* / wb_s2m_*).
// Each command produces exactly one response on a valid/ready stream (rsp_*),
// in command order. A cycle that sees no ack for TIMEOUT_CYCLES clocks is
// aborted and reported with rsp_err = 1.
// Ports:
//   wb_clk, wb_rst_n          clock, async active-low reset
//   cmd_valid/ready/we/adr/dat/sel   command stream in
//   rsp_valid/ready/dat/we/err       response stream out
//   wb_m2s_adr/dat/sel/we/cyc/stb    Wishbone master outputs
//   wb_s2m_dat/ack                   Wishbone slave returns
//   busy, fifo_level                 status

package wb_cmd_master_pkg;

  // One queued command, also the payload driven onto wb_m2s_*.
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_cmd_t;

  // One response payload.
  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] dat;
  } wb_rsp_t;

endpackage

module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic                           wb_clk,
  input  logic                           wb_rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_we,
  input  logic [31:0]                    cmd_adr,
  input  logic [31:0]                    cmd_dat,
  input  logic [3:0]                     cmd_sel,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_dat,
  output logic                           rsp_we,
  output logic                           rsp_err,
  output logic [31:0]                    wb_m2s_adr,
  output logic [31:0]                    wb_m2s_dat,
  output logic [3:0]                     wb_m2s_sel,
  output logic                           wb_m2s_we,
  output logic                           wb_m2s_cyc,
  output logic                           wb_m2s_stb,
  input  logic [31:0]                    wb_s2m_dat,
  input  logic                           wb_s2m_ack,
  output logic                           busy,
  output logic [$clog2(CMD_DEPTH):0]     fifo_level
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(CMD_DEPTH);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  wb_cmd_t              mem [CMD_DEPTH];
  wb_cmd_t              in_cmd;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic [LVL_W-1:0]     level_d;
  logic                 push;
  logic                 pop;

  state_t               state_q;
  state_t               state_d;
  wb_cmd_t              bus_q;
  wb_cmd_t              bus_d;
  logic                 cyc_q;
  logic                 cyc_d;
  logic [TO_WIDTH-1:0]  to_cnt_q;
  logic [TO_WIDTH-1:0]  to_cnt_d;
  wb_rsp_t              rsp_q;
  wb_rsp_t              rsp_d;
  logic                 rsp_valid_q;
  logic                 rsp_valid_d;
  logic                 ready_q;
  logic                 busy_q;

  assign in_cmd = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};

  // cmd_ready is registered, so a push only ever happens into a non-full FIFO.
  assign push = cmd_valid && ready_q;

  // FIFO occupancy after this edge.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Command storage; contents need no reset since level gates every read.
  always_ff @(posedge wb_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_cmd;
    end
  end

  // FIFO pointers and status; pointers wrap naturally at CMD_DEPTH.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
      ready_q <= (level_d != FULL_LVL);
      busy_q  <= (level_d != '0) || (state_d != S_IDLE);
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, bus payload, timeout counter and response.
  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    cyc_d       = cyc_q;
    to_cnt_d    = to_cnt_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop      = 1'b1;
          bus_d    = mem[rd_ptr_q];
          cyc_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is checked first so it wins over a timeout on the same edge.
        if (wb_s2m_ack) begin
          cyc_d       = 1'b0;
          rsp_d.we    = bus_q.we;
          rsp_d.err   = 1'b0;
          rsp_d.dat   = bus_q.we ? 32'h0 : wb_s2m_dat;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else if (to_cnt_q == TO_LAST) begin
          cyc_d       = 1'b0;
          rsp_d.we    = bus_q.we;
          rsp_d.err   = 1'b1;
          rsp_d.dat   = 32'h0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered Wishbone and response outputs.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      bus_q       <= '0;
      cyc_q       <= 1'b0;
      to_cnt_q    <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      bus_q       <= bus_d;
      cyc_q       <= cyc_d;
      to_cnt_q    <= to_cnt_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign fifo_level = level_q;
  assign busy       = busy_q;

  assign wb_m2s_adr = bus_q.adr;
  assign wb_m2s_dat = bus_q.dat;
  assign wb_m2s_sel = bus_q.sel;
  assign wb_m2s_we  = bus_q.we;
  assign wb_m2s_cyc = cyc_q;
  assign wb_m2s_stb = cyc_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_q.dat;
  assign rsp_we     = rsp_q.we;
  assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench for wb_cmd_master with a transaction-level
// reference model, a Wishbone slave with programmable ack behaviour, a
// per-cycle compare process and literal checks on latencies and responses.

module tb_wb_cmd_master;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned TOW     = 8;
  localparam logic [31:0] UNMAPPED = 32'hDEAD_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_s;

  logic        wb_clk;
  logic        wb_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_we;
  logic        rsp_err;
  logic [31:0] wb_m2s_adr;
  logic [31:0] wb_m2s_dat;
  logic [3:0]  wb_m2s_sel;
  logic        wb_m2s_we;
  logic        wb_m2s_cyc;
  logic        wb_m2s_stb;
  logic [31:0] wb_s2m_dat;
  logic        wb_s2m_ack;
  logic        busy;
  logic [2:0]  fifo_level;

  wb_cmd_master #(
    .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .TO_WIDTH(TOW)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_we(rsp_we), .rsp_err(rsp_err),
    .wb_m2s_adr(wb_m2s_adr), .wb_m2s_dat(wb_m2s_dat), .wb_m2s_sel(wb_m2s_sel),
    .wb_m2s_we(wb_m2s_we), .wb_m2s_cyc(wb_m2s_cyc), .wb_m2s_stb(wb_m2s_stb),
    .wb_s2m_dat(wb_s2m_dat), .wb_s2m_ack(wb_s2m_ack),
    .busy(busy), .fifo_level(fifo_level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (transaction level) ----------------
  cmd_s        m_fifo[$];
  cmd_s        m_cur       = '0;
  bit          m_on_bus    = 0;
  int          m_waited    = 0;
  bit          m_ready     = 0;
  bit          m_rsp_valid = 0;
  logic [31:0] m_rsp_dat   = '0;
  logic        m_rsp_we    = 0;
  logic        m_rsp_err   = 0;
  int          edge_no     = 0;
  int          acc_log[$];
  int          hs_log[$];

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      m_fifo.delete();
      m_cur       = '0;
      m_on_bus    = 0;
      m_waited    = 0;
      m_ready     = 0;
      m_rsp_valid = 0;
      m_rsp_dat   = '0;
      m_rsp_we    = 0;
      m_rsp_err   = 0;
    end else begin
      bit do_push;
      edge_no++;
      do_push = cmd_valid && m_ready;
      if (m_rsp_valid) begin
        if (rsp_ready) begin
          m_rsp_valid = 0;
          hs_log.push_back(edge_no);
        end
      end else if (m_on_bus) begin
        m_waited++;
        if (wb_s2m_ack) begin
          m_on_bus = 0; m_rsp_valid = 1; m_rsp_we = m_cur.we; m_rsp_err = 0;
          m_rsp_dat = m_cur.we ? 32'h0 : wb_s2m_dat;
        end else if (m_waited == TIMEOUT) begin
          m_on_bus = 0; m_rsp_valid = 1; m_rsp_we = m_cur.we; m_rsp_err = 1;
          m_rsp_dat = 32'h0;
        end
      end else if (m_fifo.size() > 0) begin
        m_cur    = m_fifo.pop_front();
        m_on_bus = 1;
        m_waited = 0;
      end
      if (do_push) begin
        m_fifo.push_back('{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel});
        acc_log.push_back(edge_no);
      end
      m_ready = (m_fifo.size() < DEPTH);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge wb_clk) begin
    chk("cmd_ready", cmd_ready, m_ready);
    chk("fifo_level", fifo_level, m_fifo.size());
    chk("busy", busy, (m_fifo.size() != 0) || m_on_bus || m_rsp_valid);
    chk("cyc", wb_m2s_cyc, m_on_bus);
    chk("stb", wb_m2s_stb, m_on_bus);
    chk("m2s_adr", wb_m2s_adr, m_cur.adr);
    chk("m2s_dat", wb_m2s_dat, m_cur.dat);
    chk("m2s_sel", wb_m2s_sel, m_cur.sel);
    chk("m2s_we", wb_m2s_we, m_cur.we);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    if (m_rsp_valid) begin
      chk("rsp_dat", rsp_dat, m_rsp_dat);
      chk("rsp_we", rsp_we, m_rsp_we);
      chk("rsp_err", rsp_err, m_rsp_err);
    end
  end

  // ---------------- bus / response monitor ----------------
  bit          prev_cyc = 0;
  int          cur_len  = 0;
  int          low_run  = 0;
  int          rise_log[$];
  int          gap_log[$];
  int          len_log[$];
  logic [33:0] rsp_log[$];

  always @(negedge wb_clk) begin
    if (wb_m2s_cyc) begin
      if (!prev_cyc) begin
        rise_log.push_back(edge_no);
        gap_log.push_back(low_run);
        cur_len = 0;
      end
      cur_len++;
      low_run = 0;
    end else begin
      if (prev_cyc) len_log.push_back(cur_len);
      low_run++;
    end
    prev_cyc = wb_m2s_cyc;
    if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_we, rsp_err, rsp_dat});
  end

  // ---------------- Wishbone slave ----------------
  int          ack_delay = 2;
  bit          silent    = 0;
  bit          spurious  = 0;
  bit          fixed_en  = 0;
  logic [31:0] fixed_dat = '0;
  int          slv_cnt   = 0;

  function automatic logic [31:0] slv_data(input logic [31:0] adr);
    return fixed_en ? fixed_dat : ~adr;
  endfunction

  initial begin
    wb_s2m_ack = 1'b0;
    wb_s2m_dat = '0;
  end

  // Acks once the cycle has been high ack_delay cycles; unmapped never acks.
  always @(posedge wb_clk) begin
    #1;
    if (wb_m2s_cyc) begin
      slv_cnt++;
      wb_s2m_ack = !silent && (wb_m2s_adr != UNMAPPED) && (slv_cnt >= ack_delay);
    end else begin
      slv_cnt = 0;
      wb_s2m_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    wb_s2m_dat = (wb_s2m_ack && wb_m2s_cyc) ? slv_data(wb_m2s_adr) : $urandom;
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  task automatic send(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    int k = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    while (!cmd_ready && k < 600) begin
      tick(1);
      k++;
    end
    if (!cmd_ready) chk("send_accept", 0, 1);
    tick(1);
    cmd_valid = 1'b0;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (rsp_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("rsp_count", rsp_log.size(), n);
  endtask

  task automatic wait_rise(input int n, input int budget);
    int k = 0;
    while (rise_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("rise_count", rise_log.size(), n);
  endtask

  task automatic clear_logs();
    acc_log.delete(); hs_log.delete(); rise_log.delete();
    gap_log.delete(); len_log.delete(); rsp_log.delete();
  endtask

  function automatic logic [33:0] rsp_at(input int i);
    return (rsp_log.size() > i) ? rsp_log[i] : 34'h3_FFFF_FFFF;
  endfunction

  function automatic int log_at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    wb_rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
    cmd_dat = '0; cmd_sel = '0; rsp_ready = 1'b0;
    tick(2);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_cyc", wb_m2s_cyc, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_level", fifo_level, 0);
    chk("reset_busy", busy, 0);
    wb_rst_n = 1'b1;
    tick(1);
    chk("post_reset_cmd_ready", cmd_ready, 1);

    // 1: write then read, ack in the third cycle
    clear_logs();
    rsp_ready = 1'b1; ack_delay = 3; fixed_en = 1; fixed_dat = 32'h0000_00A5;
    send(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF);
    send(1'b0, 32'h0000_0004, 32'h1234_5678, 4'hF);
    wait_rsp(2, 100);
    chk("t1_latency", log_at(rise_log, 0) - log_at(acc_log, 0), 1);
    chk("t1_len0", log_at(len_log, 0), 3);
    chk("t1_len1", log_at(len_log, 1), 3);
    chk("t1_gap", log_at(gap_log, 1), 2);
    chk("t1_rsp0", rsp_at(0), {1'b1, 1'b0, 32'h0});
    chk("t1_rsp1", rsp_at(1), {1'b0, 1'b0, 32'h0000_00A5});
    fixed_en = 0;

    // 2: fill the FIFO with no ack and no response consumer
    clear_logs();
    rsp_ready = 1'b0; silent = 1;
    send(1'b1, 32'h0000_0100, 32'h0000_0011, 4'h3);
    send(1'b0, 32'h0000_0104, 32'h0, 4'hF);
    send(1'b1, 32'h0000_0108, 32'h0000_0022, 4'hC);
    send(1'b0, 32'h0000_010C, 32'h0, 4'hF);
    send(1'b1, 32'h0000_0110, 32'h0000_0033, 4'hF);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ready_low", cmd_ready, 0);
    chk("t2_busy", busy, 1);
    fork
      send(1'b0, 32'h0000_0114, 32'h0, 4'hF);
    join_none
    tick(3);
    chk("t2_held_not_accepted", acc_log.size(), 5);
    silent = 0; ack_delay = 2; rsp_ready = 1'b1;
    wait_rsp(6, 200);
    chk("t2_rsp0", rsp_at(0), {1'b1, 1'b0, 32'h0});
    chk("t2_rsp1", rsp_at(1), {1'b0, 1'b0, 32'hFFFF_FEFB});
    chk("t2_rsp2", rsp_at(2), {1'b1, 1'b0, 32'h0});
    chk("t2_rsp3", rsp_at(3), {1'b0, 1'b0, 32'hFFFF_FEF3});
    chk("t2_rsp4", rsp_at(4), {1'b1, 1'b0, 32'h0});
    chk("t2_rsp5", rsp_at(5), {1'b0, 1'b0, 32'hFFFF_FEEB});
    tick(3);

    // 3: timeout on an unmapped read, next command runs normally
    clear_logs();
    send(1'b0, UNMAPPED, 32'h0, 4'hF);
    send(1'b1, 32'h0000_0200, 32'h0000_0077, 4'h1);
    wait_rsp(2, 400);
    chk("t3_len_timeout", log_at(len_log, 0), 255);
    chk("t3_rsp_err", rsp_at(0), {1'b0, 1'b1, 32'h0});
    chk("t3_len_next", log_at(len_log, 1), 2);
    chk("t3_rsp_next", rsp_at(1), {1'b1, 1'b0, 32'h0});

    // 4: ack arrives on the timeout edge
    clear_logs();
    ack_delay = 255;
    send(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    wait_rsp(1, 400);
    chk("t4_len", log_at(len_log, 0), 255);
    chk("t4_rsp", rsp_at(0), {1'b0, 1'b0, 32'hFFFF_FCFF});

    // 5: response backpressure with spurious acks while idle
    clear_logs();
    rsp_ready = 1'b0; ack_delay = 1;
    send(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    send(1'b1, 32'h0000_0404, 32'h0000_0055, 4'h1);
    begin
      int k = 0;
      while (!rsp_valid && k < 50) begin tick(1); k++; end
    end
    chk("t5_rsp_valid", rsp_valid, 1);
    spurious = 1;
    tick(10);
    chk("t5_no_new_cyc", rise_log.size(), 1);
    chk("t5_rsp_held", {rsp_we, rsp_err, rsp_dat}, {1'b0, 1'b0, 32'hFFFF_FBFF});
    rsp_ready = 1'b1;
    wait_rise(2, 20);
    chk("t5_restart", log_at(rise_log, 1) - log_at(hs_log, 0), 1);
    spurious = 0;
    wait_rsp(2, 50);
    chk("t5_rsp1", rsp_at(1), {1'b1, 1'b0, 32'h0});

    // 6: reset in the middle of a bus cycle with three commands queued
    clear_logs();
    ack_delay = 200;
    send(1'b1, 32'h0000_0500, 32'h0000_0001, 4'hF);
    send(1'b0, 32'h0000_0504, 32'h0, 4'hF);
    send(1'b1, 32'h0000_0508, 32'h0000_0002, 4'hF);
    send(1'b0, 32'h0000_050C, 32'h0, 4'hF);
    tick(2);
    chk("t6_queued", fifo_level, 3);
    chk("t6_cyc_before", wb_m2s_cyc, 1);
    #2;
    wb_rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", wb_m2s_cyc, 0);
    chk("t6_rst_stb", wb_m2s_stb, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_level", fifo_level, 0);
    tick(2);
    wb_rst_n = 1'b1;
    tick(1);
    chk("t6_ready_after", cmd_ready, 1);
    clear_logs();
    ack_delay = 2;
    send(1'b0, 32'h0000_0600, 32'h0, 4'hF);
    wait_rsp(1, 50);
    chk("t6_latency", log_at(rise_log, 0) - log_at(acc_log, 0), 1);
    chk("t6_rsp", rsp_at(0), {1'b0, 1'b0, 32'hFFFF_F9FF});
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
